// File: rtl/dcsk_pkg.sv
// Shared DCSK modulator definitions: chaos/expansion widths and the
// symbol sequencer state encoding.
package dcsk_pkg;

    localparam int CHAOS_W = 16;
    localparam int XPND_W  = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        REF   = 2'd2,
        DATA  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/dcsk_symbol_sequencer.sv
// One DCSK symbol per data bit: fetch a chaos sample, then stream the
// expanded vector as a reference half and a (possibly inverted) data half.
module dcsk_symbol_sequencer
    import dcsk_pkg::*;
#(
    parameter int CHAOS_W = dcsk_pkg::CHAOS_W,
    parameter int XPND_W  = dcsk_pkg::XPND_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_bit,
    input  logic               i_bit_valid,
    output logic               o_bit_ready,
    input  logic [CHAOS_W-1:0] i_chaos,
    input  logic               i_chaos_valid,
    output logic               o_chaos_req,
    output logic [CHAOS_W-1:0] o_xpnd_chaos,
    input  logic [XPND_W-1:0]  i_xpanded_chaos,
    output logic               o_chip,
    output logic               o_chip_valid,
    input  logic               i_chip_ready,
    output logic               o_phase,
    output logic               o_sym_done
);

    localparam int CNT_W = $clog2(XPND_W);
    localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(XPND_W - 1);

    seq_state_t         state_reg;
    logic               bit_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CHAOS_W-1:0] xpnd_chaos_reg;
    logic               bit_ready_reg;
    logic               chaos_req_reg;
    logic               chip_valid_reg;
    logic               phase_reg;

    logic chip_xfer;
    logic last_chip;

    assign chip_xfer = chip_valid_reg && i_chip_ready;
    assign last_chip = (cnt_reg == LAST_CHIP);

    // Handshake flags are registered next to the state so each one is a
    // flop output that only ever reflects its owning state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            bit_reg        <= 1'b0;
            cnt_reg        <= '0;
            xpnd_chaos_reg <= '0;
            bit_ready_reg  <= 1'b1;
            chaos_req_reg  <= 1'b0;
            chip_valid_reg <= 1'b0;
            phase_reg      <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (i_bit_valid) begin
                        bit_reg       <= i_bit;
                        state_reg     <= FETCH;
                        bit_ready_reg <= 1'b0;
                        chaos_req_reg <= 1'b1;
                    end
                end
                FETCH: begin
                    if (i_chaos_valid) begin
                        xpnd_chaos_reg <= i_chaos;
                        cnt_reg        <= '0;
                        state_reg      <= REF;
                        chaos_req_reg  <= 1'b0;
                        chip_valid_reg <= 1'b1;
                        phase_reg      <= 1'b0;
                    end
                end
                REF: begin
                    if (chip_xfer) begin
                        if (last_chip) begin
                            cnt_reg   <= '0;
                            state_reg <= DATA;
                            phase_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (chip_xfer) begin
                        if (last_chip) begin
                            cnt_reg        <= '0;
                            state_reg      <= IDLE;
                            chip_valid_reg <= 1'b0;
                            phase_reg      <= 1'b0;
                            bit_ready_reg  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    bit_ready_reg  <= 1'b1;
                    chaos_req_reg  <= 1'b0;
                    chip_valid_reg <= 1'b0;
                    phase_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign o_bit_ready  = bit_ready_reg;
    assign o_chaos_req  = chaos_req_reg;
    assign o_chip_valid = chip_valid_reg;
    assign o_phase      = phase_reg;
    assign o_xpnd_chaos = xpnd_chaos_reg;

    // Data half inverts the reference when the captured bit is 0.
    assign o_chip = chip_valid_reg
                  & (i_xpanded_chaos[cnt_reg] ^ (phase_reg & ~bit_reg));

    assign o_sym_done = (state_reg == DATA) && chip_xfer && last_chip;

endmodule

// File: tb/tb_dcsk_symbol_sequencer.sv
// Directed bench for the DCSK symbol sequencer with a behavioural stand-in
// for the chaos expander driven from o_xpnd_chaos.
module tb_dcsk_symbol_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic [15:0]  chaos;
    logic         chaos_valid;
    logic         chaos_req;
    logic [15:0]  xpnd_chaos;
    logic [255:0] xpanded;
    logic         chip;
    logic         chip_valid;
    logic         chip_ready;
    logic         phase;
    logic         sym_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dcsk_symbol_sequencer dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_bit           (bit_in),
        .i_bit_valid     (bit_valid),
        .o_bit_ready     (bit_ready),
        .i_chaos         (chaos),
        .i_chaos_valid   (chaos_valid),
        .o_chaos_req     (chaos_req),
        .o_xpnd_chaos    (xpnd_chaos),
        .i_xpanded_chaos (xpanded),
        .o_chip          (chip),
        .o_chip_valid    (chip_valid),
        .i_chip_ready    (chip_ready),
        .o_phase         (phase),
        .o_sym_done      (sym_done)
    );

    // Stand-in expansion: every output bit mixes two sample bits and a
    // per-block toggle, so each half has a distinct, sample-dependent pattern.
    function automatic logic [255:0] xpand(input logic [15:0] c);
        logic [255:0] x;
        for (int i = 0; i < 256; i++)
            x[i] = c[4'(i)] ^ c[4'(i * 7 + 3)] ^ i[4];
        return x;
    endfunction

    assign xpanded = xpand(xpnd_chaos);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bit_ready"},  32'(bit_ready),  32'd1);
        check({tag, "_chaos_req"},  32'(chaos_req),  32'd0);
        check({tag, "_xpnd_chaos"}, 32'(xpnd_chaos), 32'd0);
        check({tag, "_chip"},       32'(chip),       32'd0);
        check({tag, "_chip_valid"}, 32'(chip_valid), 32'd0);
        check({tag, "_phase"},      32'(phase),      32'd0);
        check({tag, "_sym_done"},   32'(sym_done),   32'd0);
    endtask

    // Runs one symbol starting at a falling edge in IDLE.  abort_at >= 0
    // fires an asynchronous reset at that data chip index.
    task automatic run_symbol(input logic b, input logic [15:0] c, input int delay,
                              input bit rnd, input int abort_at, input bit chk_timing);
        logic [255:0] ref_v;
        logic         r;
        logic         exp_chip;
        int           idx;
        int           guard;
        int           cyc;
        int           done_cyc;
        ref_v    = xpand(c);
        idx      = 0;
        guard    = 0;
        cyc      = 0;
        done_cyc = -1;

        check("idle_bit_ready", 32'(bit_ready), 32'd1);
        bit_in      = b;
        bit_valid   = 1'b1;
        chaos       = ~c;          // decoy: must not be taken alongside the bit
        chaos_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = ~b;            // captured bit must not follow the input
        check("fetch_req",       32'(chaos_req),  32'd1);
        check("fetch_bit_ready", 32'(bit_ready),  32'd0);
        check("fetch_valid",     32'(chip_valid), 32'd0);
        for (int k = 0; k < delay; k++) begin
            chaos_valid = 1'b0;
            @(negedge clk);
            check("wait_req",   32'(chaos_req),  32'd1);
            check("wait_valid", 32'(chip_valid), 32'd0);
        end
        chaos       = c;
        chaos_valid = 1'b1;
        @(negedge clk);
        chaos_valid = 1'b0;
        chaos       = 16'h0;
        check("capture_chaos", 32'(xpnd_chaos), 32'(c));
        check("capture_req",   32'(chaos_req),  32'd0);

        while (idx < 512 && guard < 3000) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            chip_ready = r;
            if (abort_at >= 0 && idx == 256 + abort_at) begin
                #2 rst = 1'b1;
                #1 check_reset_values("abort");
                @(negedge clk);
                check("abort_sym_done", 32'(sym_done), 32'd0);
                rst        = 1'b0;
                chip_ready = 1'b1;
                @(negedge clk);
                check("abort_idle_ready", 32'(bit_ready), 32'd1);
                return;
            end
            #1;
            exp_chip = ref_v[8'(idx)] ^ ((idx >= 256) && !b);
            check("chip_valid", 32'(chip_valid), 32'd1);
            check("chip",       32'(chip),       32'(exp_chip));
            check("phase",      32'(phase),      32'(idx >= 256));
            check("sym_done",   32'(sym_done),   32'(r && idx == 511));
            if (sym_done) done_cyc = cyc;
            @(negedge clk);
            if (r) idx++;
            cyc++;
            guard++;
        end
        chip_ready = 1'b1;
        check("chip_count", 32'(idx), 32'd512);
        if (chk_timing) check("done_latency", 32'(done_cyc), 32'd511);
        check("post_bit_ready",  32'(bit_ready),  32'd1);
        check("post_chip_valid", 32'(chip_valid), 32'd0);
        check("post_chip",       32'(chip),       32'd0);
        $display("symbol bit=%0d chaos=%04h delay=%0d rnd=%0d cycles=%0d", b, c, delay, rnd, cyc);
    endtask

    initial begin
        rst         = 1'b0;
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        chaos       = 16'h0;
        chaos_valid = 1'b0;
        chip_ready  = 1'b1;

        #12 rst = 1'b1;            // mid-clock assertion
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("release_bit_ready", 32'(bit_ready), 32'd1);

        run_symbol(1'b1, 16'h0001, 0,  1'b0, -1, 1'b1);
        run_symbol(1'b0, 16'hBEEF, 0,  1'b0, -1, 1'b1);
        run_symbol(1'b1, 16'h1234, 0,  1'b1, -1, 1'b0);
        run_symbol(1'b0, 16'hFFFF, 0,  1'b1, -1, 1'b0);
        run_symbol(1'b1, 16'h0000, 0,  1'b1, -1, 1'b0);
        run_symbol(1'b1, 16'h5A5A, 10, 1'b0, -1, 1'b1);
        run_symbol(1'b0, 16'h3C3C, 0,  1'b0, 100, 1'b0);
        $display("symbol aborted at data chip 100");
        run_symbol(1'b1, 16'h0002, 0,  1'b0, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
